// File: rtl/hub75_defs.sv
// hub75_defs: shared panel geometry, scan timing constants and scanner state encoding.
package hub75_defs;
  localparam int PANEL_W = 64;
  localparam int PANEL_H = 64;
  localparam int SCAN_ROWS = 32;
  localparam int SLOT_CYCLES = 4;
  localparam int BLANK_CYCLES = 2;
  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    BLANK = 2'd1,
    LATCH = 2'd2,
    DEAD  = 2'd3
  } state_t;
endpackage

// File: rtl/hub75_slot_timer.sv
// hub75_slot_timer: walks 65 four-phase column slots while run is high, emitting phase strobes and slot_last.
module hub75_slot_timer
  import hub75_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [6:0] col,
  output logic [3:0] p,
  output logic       slot_last
);
  logic [1:0] phase;
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 2'd0;
      col <= 7'd0;
    end else begin
      phase <= run ? phase + 2'd1 : 2'd0;
      col <= (!run || slot_last) ? 7'd0 : (phase == 2'(SLOT_CYCLES - 1)) ? col + 7'd1 : col;
    end
  end
  always_comb begin
    p = run ? 4'b0001 << phase : 4'b0000;
    slot_last = p[3] && col == 7'(PANEL_W);
  end
endmodule

// File: rtl/hub75_scanner.sv
// hub75_scanner: 64x64 1/32-scan HUB75 scan engine; requests pixels, shifts row pairs, latches and displays.
// Define HUB75_DEAD_TIME_EN to insert DEAD_CYCLES blanked cycles after each latch.
module hub75_scanner
  import hub75_defs::*;
#(
  parameter int PAINT_LAT = 1,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] frame,
  output logic [5:0]  x,
  output logic [5:0]  y,
  input  logic [2:0]  rgb,
  output logic [2:0]  panel_rgb0,
  output logic [2:0]  panel_rgb1,
  output logic [4:0]  panel_addr,
  output logic        panel_sclk,
  output logic        panel_latch,
  output logic        panel_oe_n
);
  state_t state, next;
  logic [3:0] cnt;
  logic [4:0] row;
  logic lit;
  logic [6:0] col;
  logic [3:0] p;
  logic slot_last;
  logic [2:0] top, bot;
  hub75_slot_timer u_timer (
    .clk(clk),
    .reset(reset),
    .run(state == SHIFT),
    .col(col),
    .p(p),
    .slot_last(slot_last)
  );
  always_comb begin
    next = state;
    case (state)
      SHIFT: next = slot_last ? BLANK : SHIFT;
      BLANK: next = cnt == 4'(BLANK_CYCLES - 1) ? LATCH : BLANK;
`ifdef HUB75_DEAD_TIME_EN
      LATCH: next = DEAD;
`else
      LATCH: next = SHIFT;
`endif
      DEAD:  next = cnt == 4'(DEAD_CYCLES - 1) ? SHIFT : DEAD;
      default: next = SHIFT;
    endcase
    x = col[6] ? 6'(PANEL_W - 1) : col[5:0];
    y = {state == SHIFT && !p[0], row};
  end
  // At PAINT_LAT=2 the bottom pixel arrives on the same edge it is presented, so bypass bot
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHIFT;
      cnt <= 4'd0;
      row <= 5'd0;
      frame <= 13'd0;
      lit <= 1'b0;
      top <= 3'd0;
      bot <= 3'd0;
      panel_rgb0 <= 3'd0;
      panel_rgb1 <= 3'd0;
      panel_addr <= 5'd0;
      panel_sclk <= 1'b0;
      panel_latch <= 1'b0;
      panel_oe_n <= 1'b1;
    end else begin
      state <= next;
      cnt <= next == state ? cnt + 4'd1 : 4'd0;
      row <= state == LATCH ? row + 5'd1 : row;
      frame <= (state == LATCH && row == 5'(SCAN_ROWS - 1)) ? frame + 13'd1 : frame;
      lit <= lit || state == LATCH;
      if (p[PAINT_LAT]) top <= rgb;
      if (p[PAINT_LAT + 1]) bot <= rgb;
      if (p[3] && !col[6]) begin
        panel_rgb0 <= top;
        panel_rgb1 <= PAINT_LAT == 2 ? rgb : bot;
      end
      panel_addr <= next == LATCH ? row : panel_addr;
      panel_sclk <= (p[1] || p[2]) && col != 7'd0;
      panel_latch <= next == LATCH;
      panel_oe_n <= !(next == SHIFT && (lit || state == LATCH));
    end
  end
endmodule

// File: tb/tb_hub75_scanner.sv
// tb_hub75_scanner: directed bench for hub75_scanner at PAINT_LAT 0/1/2 with per-row panel data checks.
module tb_hub75_scanner;
`ifdef HUB75_DEAD_TIME_EN
  localparam int DEAD = 4;
`else
  localparam int DEAD = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [12:0] frame [3];
  logic [5:0] x [3], y [3];
  logic [2:0] rgb [3], prgb0 [3], prgb1 [3];
  logic [4:0] addr [3];
  logic sclk [3], latch [3], oe_n [3];
  int n_chk = 0, n_pass = 0, cycle = 0;
  always @(posedge clk) cycle++;

  hub75_scanner #(.PAINT_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .frame(frame[0]), .x(x[0]), .y(y[0]), .rgb(rgb[0]),
    .panel_rgb0(prgb0[0]), .panel_rgb1(prgb1[0]), .panel_addr(addr[0]),
    .panel_sclk(sclk[0]), .panel_latch(latch[0]), .panel_oe_n(oe_n[0]));
  hub75_scanner #(.PAINT_LAT(1)) dut (
    .clk(clk), .reset(reset), .frame(frame[1]), .x(x[1]), .y(y[1]), .rgb(rgb[1]),
    .panel_rgb0(prgb0[1]), .panel_rgb1(prgb1[1]), .panel_addr(addr[1]),
    .panel_sclk(sclk[1]), .panel_latch(latch[1]), .panel_oe_n(oe_n[1]));
  hub75_scanner #(.PAINT_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .frame(frame[2]), .x(x[2]), .y(y[2]), .rgb(rgb[2]),
    .panel_rgb0(prgb0[2]), .panel_rgb1(prgb1[2]), .panel_addr(addr[2]),
    .panel_sclk(sclk[2]), .panel_latch(latch[2]), .panel_oe_n(oe_n[2]));

  function automatic logic [2:0] paint(int g, logic [5:0] px, logic [5:0] py);
    return g == 1 ? {2'b00, px == py} : {py[5], px[0], py[0]};
  endfunction
  logic [2:0] d1 [3], d2 [3];
  always @(posedge clk)
    for (int g = 0; g < 3; g++) begin
      d1[g] <= paint(g, x[g], y[g]);
      d2[g] <= d1[g];
    end
  always_comb begin
    rgb[0] = paint(0, x[0], y[0]);
    rgb[1] = d1[1];
    rgb[2] = d2[2];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic [63:0] tv [3], bv [3], e [6];
    int nc;
    logic ps;
    logic [4:0] er;
    always @(negedge clk) begin
      if (reset) begin
        nc = 0;
        ps = 1'b0;
        er = 5'd0;
        for (int k = 0; k < 3; k++) begin
          tv[k] = '0;
          bv[k] = '0;
        end
      end else begin
        if (sclk[g] && !ps && nc < 64) begin
          for (int k = 0; k < 3; k++) begin
            tv[k][nc] = prgb0[g][k];
            bv[k][nc] = prgb1[g][k];
          end
          nc++;
        end
        ps = sclk[g];
        if (latch[g]) begin
          e[0] = g == 1 ? 64'd1 << er : {64{er[0]}};
          e[1] = g == 1 ? 64'd0 : 64'hAAAA_AAAA_AAAA_AAAA;
          e[2] = 64'd0;
          e[3] = g == 1 ? 64'd1 << (er + 6'd32) : {64{er[0]}};
          e[4] = e[1];
          e[5] = g == 1 ? 64'd0 : {64{1'b1}};
          check($sformatf("sclk_rises lat%0d row%0d", g, er), 64'(nc), 64'd64);
          check($sformatf("sclk_during_latch lat%0d", g), 64'(sclk[g]), 64'd0);
          check($sformatf("latch_addr lat%0d", g), 64'(addr[g]), 64'(er));
          for (int k = 0; k < 3; k++) begin
            check($sformatf("top_bit%0d lat%0d row%0d", k, g, er), tv[k], e[k]);
            check($sformatf("bot_bit%0d lat%0d row%0d", k, g, er), bv[k], e[k + 3]);
          end
          nc = 0;
          er = er + 5'd1;
        end
      end
    end
  end

  task automatic check_reset(input string t);
    check({t, " frame"}, 64'(frame[1]), 64'd0);
    check({t, " x"}, 64'(x[1]), 64'd0);
    check({t, " y"}, 64'(y[1]), 64'd0);
    check({t, " rgb0"}, 64'(prgb0[1]), 64'd0);
    check({t, " rgb1"}, 64'(prgb1[1]), 64'd0);
    check({t, " addr"}, 64'(addr[1]), 64'd0);
    check({t, " sclk"}, 64'(sclk[1]), 64'd0);
    check({t, " latch"}, 64'(latch[1]), 64'd0);
    check({t, " oe_n"}, 64'(oe_n[1]), 64'd1);
  endtask

  task automatic wait_latch(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!latch[1] && n < 400);
    if (!latch[1]) check({tag, " latch timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int r, t, n;
    logic oe_low;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    reset = 1'b0;
    r = cycle;
    oe_low = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!latch[1] && !oe_n[1]) oe_low = 1'b1;
    end while (!latch[1] && n < 400);
    check("first_latch_cycle", 64'(cycle - r), 64'd262);
    check("oe_n_before_first_latch", 64'(oe_low), 64'd0);
    check("oe_n_on_latch", 64'(oe_n[1]), 64'd1);
    t = cycle;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (oe_n[1] && n < 20);
    check("oe_n_fall_after_latch", 64'(n), 64'(1 + DEAD));
    wait_latch("row1");
    check("row_period", 64'(cycle - t), 64'(263 + DEAD));
    for (int i = 2; i < 31; i++) wait_latch("rows");
    check("frame_before_row31", 64'(frame[1]), 64'd0);
    wait_latch("row31");
    check("addr_row31", 64'(addr[1]), 64'd31);
    check("frame_on_row31_latch", 64'(frame[1]), 64'd0);
    @(posedge clk);
    #1;
    check("frame_after_row31", 64'(frame[1]), 64'd1);
    @(negedge clk);
    dut.frame = 13'd8191;
    for (int i = 0; i < 31; i++) wait_latch("wrap_rows");
    check("frame_held_8191", 64'(frame[1]), 64'd8191);
    wait_latch("wrap_row31");
    @(posedge clk);
    #1;
    check("frame_wrap", 64'(frame[1]), 64'd0);
    for (int i = 0; i < 5; i++) wait_latch("to_row4");
    check("addr_row4", 64'(addr[1]), 64'd4);
    repeat (121) @(posedge clk);
    #1;
    check("mid_x", 64'(x[1]), 64'd30);
    check("mid_y", 64'(y[1]), 64'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrow_reset");
    @(negedge clk);
    reset = 1'b0;
    r = cycle;
    wait_latch("restart");
    check("restart_latch_cycle", 64'(cycle - r), 64'd262);
    check("restart_addr", 64'(addr[1]), 64'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
